// File: rtl/imem_pkg.sv
// Shared definitions for the run-time loadable instruction memory.
// Holds the FSM state encoding, the default widths and the NOP encoding.
package imem_pkg;

    localparam int unsigned IMEM_DATA_W = 19;
    localparam int unsigned IMEM_ADDR_W = 12;

    // The all-zero word decodes as add r0,r0,r0.
    localparam logic [IMEM_DATA_W-1:0] IMEM_NOP = {IMEM_DATA_W{1'b0}};

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2
    } imem_state_e;

endpackage

// File: rtl/imem_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// The array has no reset; the owner clears it explicitly.
module imem_ram #(
    parameter int unsigned DATA_W = 19,
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned IDX_W  = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_prog.sv
// Loadable instruction memory: zero-fills after reset, accepts a program over a
// valid/ready load port, and serves fetches with one cycle of latency.
module imem_prog
    import imem_pkg::*;
#(
    parameter int unsigned DATA_W = IMEM_DATA_W,
    parameter int unsigned ADDR_W = IMEM_ADDR_W,
    parameter int unsigned DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cur_addr,
    output logic [DATA_W-1:0] inst,
    output logic              inst_valid,
    output logic              busy,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_valid,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic [ADDR_W:0]   ld_count,
    output logic              ld_err
);

    localparam int unsigned       IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

    imem_state_e state_q, state_d;

    logic [ADDR_W-1:0] clr_ptr_q;
    logic [ADDR_W:0]   wr_ptr_q;
    logic [ADDR_W:0]   ld_count_q;
    logic              ld_err_q;
    logic              inst_valid_q;
    logic              hit_q;

    logic              ld_take;
    logic              wr_in_range;
    logic              fetch_in_range;

    logic              ram_we;
    logic              ram_re;
    logic [IDX_W-1:0]  ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // A restart pulse takes priority over any word offered in the same cycle.
    assign ld_take        = (state_q == ST_LOAD) && ld_valid && !ld_start;
    assign wr_in_range    = wr_ptr_q < DEPTH_W;
    assign fetch_in_range = {1'b0, cur_addr} < DEPTH_W;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_CLEAR: if (clr_ptr_q == CLR_LAST) state_d = ST_RUN;
            ST_RUN:   if (ld_start) state_d = ST_LOAD;
            ST_LOAD:  if (ld_take && ld_last) state_d = ST_RUN;
            default:  state_d = ST_CLEAR;
        endcase
    end

    // FSM: output decode
    always_comb begin
        busy     = (state_q != ST_RUN);
        ld_ready = (state_q == ST_LOAD);
    end

    // Pointers, load bookkeeping and fetch qualifiers
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_ptr_q    <= '0;
            wr_ptr_q     <= '0;
            ld_count_q   <= '0;
            ld_err_q     <= 1'b0;
            inst_valid_q <= 1'b0;
            hit_q        <= 1'b0;
        end else begin
            if (state_q == ST_CLEAR) begin
                clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
            end

            if (ld_start && (state_q != ST_CLEAR)) begin
                wr_ptr_q   <= {1'b0, ld_base};
                ld_count_q <= '0;
                ld_err_q   <= 1'b0;
            end else if (ld_take) begin
                // Out-of-range words are dropped; the pointer sits at DEPTH.
                if (wr_in_range) begin
                    wr_ptr_q   <= wr_ptr_q + (ADDR_W + 1)'(1);
                    ld_count_q <= ld_count_q + (ADDR_W + 1)'(1);
                end else begin
                    ld_err_q <= 1'b1;
                end
            end

            inst_valid_q <= (state_q == ST_RUN);
            hit_q        <= (state_q == ST_RUN) && fetch_in_range;
        end
    end

    always_comb begin
        ram_we    = !reset && ((state_q == ST_CLEAR) || (ld_take && wr_in_range));
        ram_waddr = (state_q == ST_CLEAR) ? clr_ptr_q[IDX_W-1:0] : wr_ptr_q[IDX_W-1:0];
        ram_wdata = (state_q == ST_CLEAR) ? '0 : ld_data;
        ram_re    = (state_q == ST_RUN) && fetch_in_range;
    end

    imem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (cur_addr[IDX_W-1:0]),
        .rdata (ram_rdata)
    );

    // Clear/load cycles and out-of-range fetches present a zero word.
    assign inst       = hit_q ? ram_rdata : '0;
    assign inst_valid = inst_valid_q;
    assign ld_count   = ld_count_q;
    assign ld_err     = ld_err_q;

endmodule
